// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer. It owns the program counter and
//               issues at most one request at a time to instruction memory
//               over a req/gnt/rvalid handshake. Returned instructions are
//               buffered in a DEPTH-entry FIFO toward decode (valid/ready).
//               A branch redirect flushes the FIFO and discards any response
//               that is still in flight.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1  clock, rising edge
//   reset        in   1  asynchronous reset, active low
//   fetch_en     in   1  1 = keep fetching; 0 = finish outstanding, then idle
//   redirect     in   1  taken branch/jump, one-cycle pulse
//   redirect_pc  in   N  branch target (bits [1:0] ignored)
//   imem_req     out  1  request to instruction memory
//   imem_addr    out  N  request address
//   imem_gnt     in   1  memory accepted the request this cycle
//   imem_rvalid  in   1  response valid
//   imem_rdata   in   N  response instruction
//   instr_valid  out  1  FIFO head valid
//   instr_ready  in   1  decode accepts the head
//   instr        out  N  head instruction
//   instr_pc     out  N  PC of the head instruction
//   pc_4         out  N  instr_pc + 4
// ============================================================================
module fetch_ctrl #(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fetch_en,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc,
  output logic [N-1:0] pc_4
);

  localparam int             AW   = $clog2(DEPTH);
  localparam int             CW   = AW + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  pc;
  logic [N-1:0]  pc_nx;
  logic [N-1:0]  req_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic          req_q;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [N-1:0]  fifo_data [DEPTH];
  logic [N-1:0]  fifo_pc   [DEPTH];

  logic grant;
  logic push;
  logic pop;

  assign grant = (state == S_REQ) && req_q && imem_gnt;
  // A response arriving in the same cycle as a redirect belongs to the old
  // path and is dropped.
  assign push  = (state == S_WAIT) && imem_rvalid && !redirect;
  // The flush wins over a simultaneous pop.
  assign pop   = (count != '0) && instr_ready && !redirect;

  // --------------------------------------------------------------------------
  // Next-state / next-count / next-pc
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    count_nx = count + CW'(push) - CW'(pop);

    if (grant) begin
      pc_nx = pc + N'(4);
    end

    if (redirect) begin
      pc_nx    = redirect_pc & ~N'(3);
      count_nx = '0;
      unique case (state)
        // One response is still owed unless it is arriving right now.
        S_WAIT:  state_nx = imem_rvalid ? S_REQ : S_DRAIN;
        S_REQ:   state_nx = grant       ? S_DRAIN : S_REQ;
        S_DRAIN: state_nx = imem_rvalid ? S_REQ : S_DRAIN;
        default: state_nx = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_IDLE: begin
          if (fetch_en) state_nx = S_REQ;
        end
        S_REQ: begin
          if (grant)          state_nx = S_WAIT;
          else if (!fetch_en) state_nx = S_IDLE;
        end
        S_WAIT: begin
          if (imem_rvalid) state_nx = fetch_en ? S_REQ : S_IDLE;
        end
        S_DRAIN: begin
          if (imem_rvalid) state_nx = S_REQ;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM and PC registers. imem_req is registered: it is computed from the
  // next state and next occupancy, which gives the same value a decode of
  // (state==REQ && count<DEPTH) would give one cycle later.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
      count  <= '0;
      req_q  <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      count <= count_nx;
      req_q <= (state_nx == S_REQ) && (count_nx < FULL);
      if (grant) begin
        req_pc <= pc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Instruction FIFO (circular buffer, DEPTH is a power of two so the
  // pointers wrap naturally).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr]   <= req_pc;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc;
  assign instr_valid = (count != '0);
  assign instr       = fifo_data[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];
  assign pc_4        = instr_pc + N'(4);

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Randomized self-checking bench for fetch_ctrl. A memory model
//               answers granted requests after a random latency with data
//               derived from the address; a queue-based reference model of
//               the instruction stream predicts every fetch address and the
//               FIFO head seen by decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam int N     = 32;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         fetch_en;
  logic         redirect;
  logic [N-1:0] redirect_pc;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [N-1:0] imem_rdata;
  logic         instr_valid;
  logic         instr_ready;
  logic [N-1:0] instr;
  logic [N-1:0] instr_pc;
  logic [N-1:0] pc_4;

  fetch_ctrl #(.N(N), .RESET_PC('0), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_en   (fetch_en),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .pc_4       (pc_4)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F0F;
  endfunction

  // Reference model state
  logic [31:0] q_data [$];
  logic [31:0] q_pc   [$];
  logic [31:0] exp_fetch_pc;
  bit          mem_out;
  bit          mem_killed;
  int          mem_dly;
  logic [31:0] mem_addr;
  int unsigned n_pops;
  int unsigned n_grants;
  bit          prev_wait;
  logic [31:0] prev_addr;

  task automatic model_reset();
    q_data.delete();
    q_pc.delete();
    exp_fetch_pc = 32'h0;
    mem_out      = 1'b0;
    mem_killed   = 1'b0;
    mem_dly      = 0;
    mem_addr     = 32'h0;
    prev_wait    = 1'b0;
    prev_addr    = 32'h0;
  endtask

  task automatic drive_idle();
    fetch_en    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   32'(imem_req),    32'h0);
    check_eq({tag, "_addr"},  imem_addr,        32'h0);
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'h0);
    check_eq({tag, "_instr"}, instr,            32'h0);
    check_eq({tag, "_ipc"},   instr_pc,         32'h0);
    check_eq({tag, "_pc4"},   pc_4,             32'h4);
  endtask

  // One clock cycle: drive inputs at the falling edge, check the outputs,
  // then advance the model by what the upcoming rising edge will do.
  task automatic cycle();
    bit gnt_ev, rv_ev, pop_ev;
    @(negedge clk);
    fetch_en    = ($urandom_range(0, 9) != 0);
    instr_ready = ($urandom_range(0, 2) != 0);
    redirect    = ($urandom_range(0, 24) == 0);
    case ($urandom_range(0, 3))
      0:       redirect_pc = 32'h0000_0103;
      1:       redirect_pc = 32'hFFFF_FFF6;
      2:       redirect_pc = 32'hFFFF_FFFF;
      default: redirect_pc = $urandom;
    endcase
    imem_gnt    = imem_req && !mem_out && ($urandom_range(0, 2) != 0);
    imem_rvalid = mem_out && (mem_dly == 0);
    imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
    #1;

    check_eq("valid", 32'(instr_valid), 32'(q_data.size() != 0));
    if (q_data.size() != 0) begin
      check_eq("instr",    instr,    q_data[0]);
      check_eq("instr_pc", instr_pc, q_pc[0]);
      check_eq("pc_4",     pc_4,     q_pc[0] + 32'd4);
    end
    if (imem_req) begin
      check_eq("req_outstanding", 32'(mem_out), 32'h0);
      check_eq("req_full",        32'(q_data.size() < DEPTH), 32'h1);
      check_eq("req_addr",        imem_addr, exp_fetch_pc);
    end
    if (prev_wait) begin
      check_eq("req_hold",  32'(imem_req), 32'h1);
      check_eq("addr_hold", imem_addr,     prev_addr);
    end

    gnt_ev = imem_req && imem_gnt;
    rv_ev  = imem_rvalid;
    pop_ev = instr_valid && instr_ready;

    prev_wait = imem_req && !imem_gnt && !redirect && fetch_en;
    prev_addr = imem_addr;

    if (pop_ev && !redirect && q_data.size() != 0) begin
      void'(q_data.pop_front());
      void'(q_pc.pop_front());
      n_pops++;
    end
    if (rv_ev) begin
      if (!mem_killed && !redirect) begin
        q_data.push_back(imem_rdata);
        q_pc.push_back(mem_addr);
      end
      mem_out = 1'b0;
    end else if (mem_out) begin
      mem_dly--;
    end
    if (gnt_ev) begin
      n_grants++;
      mem_out      = 1'b1;
      mem_killed   = 1'b0;
      mem_addr     = imem_addr;
      mem_dly      = $urandom_range(0, 2);
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    if (redirect) begin
      q_data.delete();
      q_pc.delete();
      if (mem_out) mem_killed = 1'b1;
      exp_fetch_pc = redirect_pc & ~32'h3;
    end
  endtask

  initial begin
    n_pops   = 0;
    n_grants = 0;
    model_reset();
    drive_idle();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;

    repeat (3000) cycle();

    // Asynchronous reset part-way through traffic: outputs must clear
    // immediately, without waiting for a clock edge.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    repeat (3000) cycle();

    check_eq("progress_pops",   32'(n_pops > 500),   32'h1);
    check_eq("progress_grants", 32'(n_grants > 500), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch sequencer for the instruction-fetch stage.
- Owns the program counter and issues one request at a time to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a DEPTH-entry FIFO toward decode with a valid/ready handshake.
- Handles branch redirects by flushing the FIFO and discarding any in-flight response.

Parameters:
- n, 32, datapath width of PC, addresses and instruction words
- RESET_PC, 0, PC value loaded on reset
- DEPTH, 2, instruction FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- fetch_en  in  1  1 = issue new fetches; 0 = finish the outstanding fetch, then idle
- redirect  in  1  taken branch/jump, one-cycle pulse
- redirect_pc  in  n  branch target
- imem_req  out  1  request to instruction memory
- imem_addr  out  n  request address
- imem_gnt  in  1  memory accepted the request this cycle
- imem_rvalid  in  1  response valid
- imem_rdata  in  n  response instruction
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decode accepts the head
- instr  out  n  head instruction
- instr_pc  out  n  PC of the head instruction
- pc_4  out  n  instr_pc + 4

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC, state=IDLE, FIFO count=0.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, pc_4=4.
- FSM states: IDLE, REQ, WAIT, DRAIN.
- IDLE: imem_req=0. If fetch_en=1, go to REQ next cycle.
- REQ:
  - imem_addr=pc; imem_req=1 only while count<DEPTH.
  - While imem_req=1 && imem_gnt=0, imem_req and imem_addr stay stable.
  - On imem_req && imem_gnt: latch req_pc=pc, set pc<=pc+4 (mod 2^n wrap), go to WAIT.
  - If fetch_en=0 and no request is granted this cycle, go to IDLE.
- WAIT:
  - imem_req=0. imem_rvalid arrives at least 1 cycle after gnt.
  - On imem_rvalid: push {imem_rdata, req_pc} into the FIFO, then go to REQ if fetch_en=1, else IDLE.
  - A slot was reserved at grant time, so the push never overflows.
- DRAIN: imem_req=0. On imem_rvalid, drop the data (no push), then go to REQ.
- Redirect (highest priority, any state except reset):
  - pc<=redirect_pc with bits [1:0] forced to 0; FIFO count<=0.
  - If a request is outstanding (state WAIT, or REQ with imem_gnt=1 in the same cycle), go to DRAIN; otherwise go to REQ.
  - Redirect in DRAIN: stay in DRAIN (still exactly one response owed), and pc takes the new target.
- FIFO:
  - instr_valid = (count!=0); instr and instr_pc come from the head register; pc_4 = instr_pc+4 (wraps).
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Redirect with a pop in the same cycle: the flush wins and count=0.
  - Redirect with imem_rvalid in WAIT in the same cycle: that response is dropped, and the next state is REQ (nothing outstanding).
- Outstanding requests never exceed 1. The memory sees no imem_req while in WAIT or DRAIN.
- An async reset mid-transaction abandons any in-flight response. The memory must also be reset by the same reset.

Test Plan:
- Reset then fetch_en=1, imem_gnt=1 every cycle, imem_rvalid 1 cycle after gnt, instr_ready=1 -> imem_addr sequence 0,4,8,…; instr_pc follows 0,4,8 with matching rdata; pc_4=instr_pc+4.
- instr_ready=0 with continuous fetches -> exactly DEPTH=2 pushes (PCs 0,4); imem_req drops to 0 while full. Then instr_ready=1 -> the head pops in order and fetching resumes at 8.
- Redirect to 0x103 while in WAIT -> pending rvalid data discarded, FIFO empty, next imem_addr=0x100, next instr_pc=0x100.
- Redirect in the same cycle as imem_gnt in REQ -> state DRAIN; the granted response is dropped and the next request address is the redirect target.
- imem_gnt held low 5 cycles -> imem_req and imem_addr stable throughout; pc advances only after gnt.
- pc=2^n−4 (set via redirect) -> the following fetch address is 0 (wrap). Assert reset mid-WAIT -> all outputs return to reset values immediately.
